bus_cycle_unit: RTL

Parametrised machine-cycle sequencer for the 8080/8085-class core. It turns one request (opcode fetch, memory read or write, I/O read or write) into a T-state bus cycle with ALE, status lines, strobes and READY-driven wait states. It sits between the instruction/execute sequencer and the external bus, replacing hand-coded per-state strobe logic. Width, wait-state limit and I/O address width are generalised by parameters.

---
 rtl/bus_cycle_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_cycle_unit.sv
// 8080/8085-class machine-cycle sequencer; `BUS_TIMEOUT_EN adds a TW abort after TIMEOUT wait states.
// Latency: accept to rsp_valid is 4 cycles (rd/wr) or 5 (fetch) plus 1 per TW; reserved types answer next cycle.
// Backpressure: req_ready is high only in IDLE, including the rsp_valid cycle, so bus cycles run back to back.

module bus_cycle_unit #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 8,
   parameter int IO_ADDR_W = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic              clock,
   input  logic              reset_in,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_type,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] ADD,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              ALE,
   output logic              RDn,
   output logic              WRn,
   output logic              IO_Mn,
   output logic              S1,
   output logic              S0,
   input  logic              READY
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_T1,
      ST_T2,
      ST_TW,
      ST_T3,
      ST_T4
   } state_t;

   localparam logic [ADDR_W-1:0] IO_MASK = {ADDR_W{1'b1}} >> (ADDR_W - IO_ADDR_W);

   if (IO_ADDR_W > ADDR_W || IO_ADDR_W < 1 || TIMEOUT < 1) begin : g_bad_params
      $error("bus_cycle_unit: illegal parameter combination");
   end

   state_t            state;
   logic              cyc_fetch;
   logic              cyc_read;
   logic              cyc_write;

   logic              typ_fetch;
   logic              typ_read;
   logic              typ_write;
   logic              typ_io;
   logic              typ_rsvd;
   logic              accept;
   logic [ADDR_W-1:0] bus_addr;

`ifdef BUS_TIMEOUT_EN
   localparam int TW_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   logic [TW_W-1:0]   tw_cnt;
`endif

   // Request decode; fetch counts as a read for strobe and capture purposes.
   always_comb begin
      typ_fetch = (req_type == 3'b000);
      typ_read  = (req_type == 3'b000) || (req_type == 3'b001) || (req_type == 3'b011);
      typ_write = (req_type == 3'b010) || (req_type == 3'b100);
      typ_io    = (req_type == 3'b011) || (req_type == 3'b100);
      typ_rsvd  = (req_type > 3'b100);
      accept    = req_valid && req_ready;
      bus_addr  = typ_io ? (req_addr & IO_MASK) : req_addr;
   end

   always_ff @(posedge clock) begin
      if (reset_in) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         ADD       <= '0;
         data_out  <= '0;
         data_oe   <= 1'b0;
         ALE       <= 1'b0;
         RDn       <= 1'b1;
         WRn       <= 1'b1;
         IO_Mn     <= 1'b0;
         S1        <= 1'b0;
         S0        <= 1'b0;
         cyc_fetch <= 1'b0;
         cyc_read  <= 1'b0;
         cyc_write <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         tw_cnt    <= '0;
`endif
      end else begin
         ALE       <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (typ_rsvd) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else begin
                     state     <= ST_T1;
                     req_ready <= 1'b0;
                     ALE       <= 1'b1;
                     ADD       <= bus_addr;
                     IO_Mn     <= typ_io;
                     S1        <= typ_read;
                     S0        <= typ_fetch || typ_write;
                     cyc_fetch <= typ_fetch;
                     cyc_read  <= typ_read;
                     cyc_write <= typ_write;
                     if (typ_write) begin
                        data_out <= req_wdata;
                     end
                  end
               end
            end

            ST_T1: begin
               state   <= ST_T2;
               RDn     <= !cyc_read;
               WRn     <= !cyc_write;
               data_oe <= cyc_write;
`ifdef BUS_TIMEOUT_EN
               tw_cnt  <= '0;
`endif
            end

            ST_T2: begin
               if (READY) begin
                  state <= ST_T3;
               end else begin
                  state  <= ST_TW;
`ifdef BUS_TIMEOUT_EN
                  tw_cnt <= TW_W'(1);
`endif
               end
            end

            ST_TW: begin
`ifdef BUS_TIMEOUT_EN
               // The abort wins over a late READY once the wait budget is spent.
               if (tw_cnt >= TW_W'(TIMEOUT)) begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
                  RDn       <= 1'b1;
                  WRn       <= 1'b1;
                  data_oe   <= 1'b0;
                  IO_Mn     <= 1'b0;
                  S1        <= 1'b0;
                  S0        <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end else if (READY) begin
                  state <= ST_T3;
               end else begin
                  tw_cnt <= tw_cnt + 1'b1;
               end
`else
               if (READY) begin
                  state <= ST_T3;
               end
`endif
            end

            ST_T3: begin
               RDn     <= 1'b1;
               WRn     <= 1'b1;
               data_oe <= 1'b0;
               if (cyc_read) begin
                  rsp_rdata <= data_in;
               end
               if (cyc_fetch) begin
                  state <= ST_T4;
               end else begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
                  IO_Mn     <= 1'b0;
                  S1        <= 1'b0;
                  S0        <= 1'b0;
                  rsp_valid <= 1'b1;
               end
            end

            ST_T4: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               IO_Mn     <= 1'b0;
               S1        <= 1'b0;
               S0        <= 1'b0;
               rsp_valid <= 1'b1;
            end

            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
